// File: rtl/seven_seg_mux_scanner.sv
// Purpose : time-multiplexed N-digit common-anode 7-segment scanner with an
//           inter-digit blanking guard, hex decode and per-frame input snapshot.
// Latency : all outputs registered; a frame is NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES)
//           div_clk cycles, and the first frame starts on the edge that sees enable=1.
// Backpressure: none; enable=0 parks the scan in IDLE with the display dark on the next edge.
//
// Ports:
//   div_clk, reset_n        scan clock (rising edge), async active-low reset
//   enable                  run the scan; low darkens the display and parks at digit 0
//   digit_data/digit_en/dp  per-digit hex nibble, display enable, decimal point
//   an, seg, dp_n           active-low anodes, segments (seg[0]=a..seg[6]=g), decimal point
//   digit_sel, frame_start  digit being visited; one-cycle pulse on the first cycle of a frame
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- darkens leading zero digits
// (value 0 and no decimal point on that digit and on every higher digit);
// digit 0 is never blanked.

module seven_seg_mux_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                          div_clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [NUM_DIGITS-1:0]         dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          frame_start
);

    localparam int SEL_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // Only meaningful when BLANK_CYCLES > 0; BLANK is unreachable otherwise.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Every digit visit starts here: the guard when one is configured.
    localparam state_t VISIT_ST = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [SEL_W-1:0]          sel_nxt;
    logic                      fs_nxt;
    logic [4*NUM_DIGITS-1:0]   snap_data, snap_data_nxt;
    logic [NUM_DIGITS-1:0]     snap_en, snap_en_nxt;
    logic [NUM_DIGITS-1:0]     snap_dp, snap_dp_nxt;
    logic                      take_snap;
    logic [NUM_DIGITS-1:0]     sup_mask;
    logic [NUM_DIGITS-1:0]     an_nxt;
    logic [6:0]                seg_nxt;
    logic                      dp_n_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h7F;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; the run of suppressible digits ends at the
    // first non-zero value or lit decimal point.
    always_comb begin
        logic lead;
        lead     = 1'b1;
        sup_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead        = lead & (digit_data[4*i +: 4] == 4'h0) & ~dp[i];
            sup_mask[i] = lead;
        end
    end
`else
    assign sup_mask = '0;
`endif

    // Next-state, counter, digit pointer and snapshot control.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = digit_sel;
        fs_nxt    = 1'b0;
        take_snap = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    take_snap = 1'b1;
                    fs_nxt    = 1'b1;
                    sel_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = VISIT_ST;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SHOW;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHOW: begin
                if (cnt == DWELL_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = VISIT_ST;
                    if (digit_sel == LAST_SEL) begin
                        // Frame boundary: re-sample inputs so the next frame is coherent.
                        sel_nxt   = '0;
                        take_snap = 1'b1;
                        fs_nxt    = 1'b1;
                    end else begin
                        sel_nxt = digit_sel + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                sel_nxt   = '0;
            end
        endcase

        // Disable wins over everything: abandon the visit immediately.
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sel_nxt   = '0;
            fs_nxt    = 1'b0;
            take_snap = 1'b0;
        end
    end

    // Suppressed digits are folded into the enable snapshot so the display
    // path only has to look at one mask.
    always_comb begin
        snap_data_nxt = snap_data;
        snap_en_nxt   = snap_en;
        snap_dp_nxt   = snap_dp;
        if (take_snap) begin
            snap_data_nxt = digit_data;
            snap_en_nxt   = digit_en & ~sup_mask;
            snap_dp_nxt   = dp;
        end
    end

    // Outputs are computed from the next-state values so the registered pins
    // line up with the registered state.
    always_comb begin
        an_nxt   = '1;
        seg_nxt  = 7'h7F;
        dp_n_nxt = 1'b1;
        if (state_nxt == SHOW && snap_en_nxt[sel_nxt]) begin
            an_nxt[sel_nxt] = 1'b0;
            seg_nxt         = hex_to_seg(snap_data_nxt[{sel_nxt, 2'b00} +: 4]);
            dp_n_nxt        = ~snap_dp_nxt[sel_nxt];
        end
    end

    always_ff @(posedge div_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
            snap_data   <= '0;
            snap_en     <= '0;
            snap_dp     <= '0;
            an          <= '1;
            seg         <= 7'h7F;
            dp_n        <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            digit_sel   <= sel_nxt;
            frame_start <= fs_nxt;
            snap_data   <= snap_data_nxt;
            snap_en     <= snap_en_nxt;
            snap_dp     <= snap_dp_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp_n        <= dp_n_nxt;
        end
    end

    // Two lit anodes would short two digits onto one segment bus.
    a_one_anode: assert property (@(posedge div_clk) disable iff (!reset_n) $onehot0(~an))
        else $error("more than one anode driven low: an=%b", an);

endmodule
